// File: rtl/gmii_tx_arbiter.sv
// Two-port GMII transmit arbiter: grants the shared, registered GMII output to one
// requester at a time and enforces an inter-frame gap and a grant-to-start timeout.
module gmii_tx_arbiter #(
    parameter int IFG_CYCLES    = 12,
    parameter int START_TIMEOUT = 64,
    parameter int PRIO_MODE     = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    output logic        gnt0,
    input  logic [7:0]  txd0,
    input  logic        txen0,
    input  logic        req1,
    output logic        gnt1,
    input  logic [7:0]  txd1,
    input  logic        txen1,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic        dbg_timeout,
    output logic [15:0] dbg_frames0,
    output logic [15:0] dbg_frames1
);

    localparam int TW = $clog2(START_TIMEOUT) + 1;
    localparam int IW = $clog2(IFG_CYCLES) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(START_TIMEOUT - 1);
    localparam logic [IW-1:0] I_LAST = IW'(IFG_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BUSY, S_IFG} state_t;

    state_t        state, state_nxt;
    logic          owner, owner_nxt;
    logic          last, last_nxt;
    logic [TW-1:0] tcnt;
    logic [IW-1:0] icnt;
    logic          winner;
    logic          own_req, own_txen;
    logic [7:0]    own_txd;
    logic          frame_done, timeout_hit;
    logic          granted;

    // State and bookkeeping registers; both counters clear on every state change.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state       <= S_IDLE;
            owner       <= 1'b0;
            last        <= 1'b1;
            tcnt        <= '0;
            icnt        <= '0;
            dbg_timeout <= 1'b0;
            dbg_frames0 <= '0;
            dbg_frames1 <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
            if (state_nxt != state) begin
                tcnt <= '0;
                icnt <= '0;
            end else begin
                if (state == S_WAIT) tcnt <= tcnt + 1'b1;
                if (state == S_IFG)  icnt <= icnt + 1'b1;
            end
            if (timeout_hit) dbg_timeout <= 1'b1;
            if (frame_done && !owner) dbg_frames0 <= dbg_frames0 + 16'd1;
            if (frame_done &&  owner) dbg_frames1 <= dbg_frames1 + 16'd1;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first so no path can
        // leave it unassigned and infer a latch.
        state_nxt   = state;
        owner_nxt   = owner;
        last_nxt    = last;
        frame_done  = 1'b0;
        timeout_hit = 1'b0;
        own_req     = owner ? req1  : req0;
        own_txen    = owner ? txen1 : txen0;
        own_txd     = owner ? txd1  : txd0;
        if (req0 && req1) winner = (PRIO_MODE != 0) ? 1'b1 : ~last;
        else              winner = req1;

        case (state)
            S_IDLE: if (req0 || req1) begin
                state_nxt = S_WAIT;
                owner_nxt = winner;
            end
            S_WAIT: begin
                if (own_txen) begin
                    state_nxt = S_BUSY;
                end else if (!own_req) begin
                    state_nxt = S_IDLE;
                end else if (tcnt == T_LAST) begin
                    state_nxt   = S_IDLE;
                    timeout_hit = 1'b1;
                    last_nxt    = owner;
                end
            end
            S_BUSY: if (!own_txen) begin
                state_nxt  = S_IFG;
                frame_done = 1'b1;
                last_nxt   = owner;
            end
            S_IFG: if (icnt == I_LAST) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        granted    = (state == S_WAIT) || (state == S_BUSY);
        gnt0       = granted && !owner;
        gnt1       = granted &&  owner;
        gmii_tx_er = 1'b0;
    end

    // Only the owner's lane is ever selected, so the other port cannot leak out.
    always_ff @(posedge clk) begin
        if (rst) begin
            gmii_txd   <= 8'h00;
            gmii_tx_en <= 1'b0;
        end else if (granted) begin
            gmii_txd   <= own_txd;
            gmii_tx_en <= own_txen;
        end else begin
            gmii_txd   <= 8'h00;
            gmii_tx_en <= 1'b0;
        end
    end

endmodule

// File: doc/gmii_tx_arbiter.md
GMII_TX_ARBITER -- requirements
Module: gmii_tx_arbiter

Interface
REQ-001 Parameters SHALL be IFG_CYCLES, default 12, minimum idle cycles between frames; START_TIMEOUT, default 64, grant-to-tx_en limit in cycles; PRIO_MODE, default 0 (0 = round-robin, 1 = fixed priority to port 1).
REQ-002 clk  in  1  single clock for all logic.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 req0  in  1  port 0 (image line transmitter) requests the GMII.
REQ-005 gnt0  out  1  port 0 owns the GMII.
REQ-006 txd0  in  8  port 0 GMII data.
REQ-007 txen0  in  1  port 0 GMII enable.
REQ-008 req1, gnt1, txd1, txen1  SHALL have the same widths and meanings as the port 0 signals, for port 1 (control/ARP transmitter).
REQ-009 gmii_txd  out  8  shared GMII data, registered.
REQ-010 gmii_tx_en  out  1  shared GMII enable, registered.
REQ-011 gmii_tx_er  out  1  tied to 0.
REQ-012 dbg_timeout  out  1  sticky; set on any start timeout.
REQ-013 dbg_frames0, dbg_frames1  out  16 each  count of completed frames per port; wrap at 0xFFFF to 0.

Function
REQ-014 The state machine SHALL have four states: S_IDLE, S_WAIT (granted, no tx_en yet), S_BUSY (frame in progress) and S_IFG (gap).
REQ-015 In S_IDLE, if any req is high, the arbiter SHALL select a winner and go to S_WAIT; the matching gnt SHALL rise on the next clock.
REQ-016 Winner selection with only one req high: that port wins.
REQ-017 Winner selection with both req high and PRIO_MODE=1: port 1 wins.
REQ-018 Winner selection with both req high and PRIO_MODE=0: the port not served last wins; the last-served pointer resets to port 1, so port 0 wins first.
REQ-019 At most one gnt SHALL be high in any cycle; gnt SHALL stay high through S_WAIT and S_BUSY.
REQ-020 In S_WAIT, the granted port's txen SHALL move the arbiter to S_BUSY.
REQ-021 In S_WAIT, if the granted req drops before txen rises: gnt falls next clock, state returns to S_IDLE, no IFG, no frame counted.
REQ-022 In S_WAIT, if START_TIMEOUT cycles elapse without txen: gnt falls, dbg_timeout is set to 1, state returns to S_IDLE, the last-served pointer is updated to the timed-out port.
REQ-023 In S_BUSY, the first sampled txen=0 of the granted port SHALL cause gnt to fall next clock, increment that port's frame counter, update the last-served pointer, and enter S_IFG.
REQ-024 S_IFG SHALL last exactly IFG_CYCLES clocks, then go to S_IDLE; req is ignored during S_IFG.
REQ-025 Datapath: each cycle, gmii_txd/gmii_tx_en SHALL take the granted port's txd/txen; latency is one clock.
REQ-026 When no port is granted, or in S_IFG, gmii_tx_en and gmii_txd SHALL register 0.
REQ-027 A non-granted port's txen/txd SHALL never reach the outputs.
REQ-028 Output gap guarantee: the gap between the falling gmii_tx_en of one frame and the next rising gmii_tx_en SHALL be at least IFG_CYCLES clocks.
REQ-029 Timeout counter width SHALL be clog2(START_TIMEOUT)+1 bits; IFG counter width SHALL be clog2(IFG_CYCLES)+1 bits; both clear on every state entry.
REQ-030 A requester that re-asserts req in the same cycle its frame ends SHALL be served only after S_IFG, and SHALL lose to the other port when both request in round-robin mode.

Reset
REQ-031 While rst is high at a clock edge: state S_IDLE, gnt0=gnt1=0, gmii_txd=0x00, gmii_tx_en=0, dbg_timeout=0, dbg_frames0=dbg_frames1=0, last-served pointer=port 1, counters 0.
REQ-032 Reset asserted mid-frame SHALL drop gmii_tx_en on the next clock with no IFG enforced afterwards.

Verification
REQ-033 Single port 0 frame: req0=1, txen0 high for 100 cycles with txd0 incrementing -> gnt0 rises 1 cycle after req; gmii_txd equals txd0 delayed 1 cycle for all 100 bytes; dbg_frames0=1; gnt0 low and no output for 12 cycles after.
REQ-034 Contention in round-robin mode: req0=req1=1 continuously, 3 frames of 20 cycles each -> grant order 0, 1, 0; gmii_tx_en low for at least 12 cycles between frames; dbg_frames0=2, dbg_frames1=1.
REQ-035 Fixed priority: PRIO_MODE=1, both req high for 3 frames -> all grants go to port 1; port 0 gets a grant only after req1 drops.
REQ-036 Timeout: req1=1, txen1 never asserted -> gnt1 falls after 64 cycles, dbg_timeout=1 sticky; a pending req0 is granted in the next S_IDLE cycle.
REQ-037 Isolation: port 0 granted, txen1 and txd1=0xAA toggled throughout -> 0xAA never appears on gmii_txd while txen1 is not granted.
REQ-038 Reset mid-frame: rst pulsed at byte 50 of a port 0 frame -> gmii_tx_en=0 on the next clock, all counters 0, and a new request is granted normally after rst falls.
